// File: rtl/crosshair_pkg.sv
// Shared constants, FSM state type and coordinate step helper for the
// crosshair position controller.
package crosshair_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int MARGIN_DEF   = 18;
  localparam int COORD_W      = 10;
  // One extra bit so that a step below zero or past the top stays representable.
  localparam int CALC_W       = COORD_W + 1;

  // Per-button auto-repeat state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  // Move one coordinate by (step_m1 + 1) towards lo (dir_dec=1) or hi.
  // An out-of-range result either saturates at the limit it crossed or
  // wraps to the opposite limit.
  function automatic logic [COORD_W-1:0] step_coord(
    input logic [COORD_W-1:0] cur,
    input logic [3:0]         step_m1,
    input logic               dir_dec,
    input logic [COORD_W-1:0] lo,
    input logic [COORD_W-1:0] hi,
    input logic               wrap
  );
    logic signed [CALC_W-1:0] cur_v;
    logic signed [CALC_W-1:0] step_v;
    logic signed [CALC_W-1:0] sum_v;
    logic signed [CALC_W-1:0] lo_v;
    logic signed [CALC_W-1:0] hi_v;
    logic [COORD_W-1:0]       res;
    cur_v  = $signed({1'b0, cur});
    lo_v   = $signed({1'b0, lo});
    hi_v   = $signed({1'b0, hi});
    step_v = $signed({{(CALC_W-4){1'b0}}, step_m1}) + 11'sd1;
    if (dir_dec) begin
      sum_v = cur_v - step_v;
    end else begin
      sum_v = cur_v + step_v;
    end
    if (sum_v > hi_v) begin
      res = wrap ? lo : hi;
    end else if (sum_v < lo_v) begin
      res = wrap ? hi : lo;
    end else begin
      res = sum_v[COORD_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/crosshair_pos_ctrl_btn_debounce.sv
// Button conditioner: two-flop synchroniser followed by a stability counter.
// The debounced level follows the synchronised input only after it has
// disagreed for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the
// count. rise pulses for one cycle together with a 0->1 change of dout.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dout_r;
  logic             rise_r;
  logic             differ_s;
  logic             accept_s;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Decide whether this cycle completes a full stable interval.
  always_comb begin
    differ_s = sync2_r ^ dout_r;
    if (differ_s && (cnt_r == CNT_LAST)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Stability counter, debounced level and rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CNT_W{1'b0}};
      dout_r <= 1'b0;
      rise_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r  <= {CNT_W{1'b0}};
      dout_r <= sync2_r;
      rise_r <= sync2_r;
    end else if (differ_s) begin
      cnt_r  <= cnt_r + CNT_W'(1'b1);
      rise_r <= 1'b0;
    end else begin
      cnt_r  <= {CNT_W{1'b0}};
      rise_r <= 1'b0;
    end
  end

  assign dout = dout_r;
  assign rise = rise_r;

endmodule

// File: rtl/crosshair_pos_ctrl.sv
// Crosshair position controller (pixel-clock domain).
// Debounced buttons request increment/decrement/recentre; requests are held
// pending and committed only on the vsync rising edge, so the overlay never
// moves mid-frame. Holding a direction button auto-repeats once per frame
// after REPEAT_FRAMES frames.
// Build option: define CROSSHAIR_WRAP_EN to make out-of-range moves wrap to
// the opposite limit instead of saturating.
module crosshair_pos_ctrl
  import crosshair_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int MARGIN          = MARGIN_DEF,
  parameter int X_INIT          = 300,
  parameter int Y_INIT          = 240,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_FRAMES   = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic [2:0]         btn,
  input  logic [7:0]         sw,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic               moved
);

  localparam int FC_W = $clog2(REPEAT_FRAMES + 1);

  localparam logic [COORD_W-1:0] LO_LIM = COORD_W'(MARGIN);
  localparam logic [COORD_W-1:0] X_HI   = COORD_W'(H_ACTIVE - 1 - MARGIN);
  localparam logic [COORD_W-1:0] Y_HI   = COORD_W'(V_ACTIVE - 1 - MARGIN);
  localparam logic [COORD_W-1:0] X_RST  = COORD_W'(X_INIT);
  localparam logic [COORD_W-1:0] Y_RST  = COORD_W'(Y_INIT);

`ifdef CROSSHAIR_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  logic               vsync_q_r;
  logic               frame_tick_s;
  logic [2:0]         db_level_s;
  logic [2:0]         db_rise_s;
  btn_state_t         state_r     [2];
  logic [FC_W-1:0]    frame_cnt_r [2];
  logic [1:0]         repeat_fire_s;
  logic               pend_inc_r;
  logic               pend_dec_r;
  logic               pend_ctr_r;
  logic               req_inc_s;
  logic               req_dec_s;
  logic               req_ctr_s;
  logic [COORD_W-1:0] cursor_x_r;
  logic [COORD_W-1:0] cursor_y_r;
  logic               moved_r;
  logic [COORD_W-1:0] axis_cur_s;
  logic [COORD_W-1:0] axis_hi_s;
  logic [COORD_W-1:0] axis_new_s;
  logic [COORD_W-1:0] next_x_s;
  logic [COORD_W-1:0] next_y_s;
  logic               changed_s;
  logic               sw_unused_s;

  assign sw_unused_s = ^{sw[3:1], db_level_s[2]};

  // One conditioner per button: [0]=inc, [1]=dec, [2]=recentre.
  for (genvar i = 0; i < 3; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (btn[i]),
      .dout (db_level_s[i]),
      .rise (db_rise_s[i])
    );
  end

  // Registered vsync; resets high so the first cycle after reset is no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q_r <= 1'b1;
    end else begin
      vsync_q_r <= vsync;
    end
  end

  // Frame boundary detect and per-button auto-repeat firing.
  always_comb begin
    frame_tick_s  = vsync & ~vsync_q_r;
    repeat_fire_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (frame_tick_s && (state_r[i] == REPEAT)) begin
        repeat_fire_s[i] = 1'b1;
      end else begin
        repeat_fire_s[i] = 1'b0;
      end
    end
  end

  // Auto-repeat FSM for the increment and decrement buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_r[i]     <= IDLE;
        frame_cnt_r[i] <= {FC_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!db_level_s[i]) begin
          state_r[i]     <= IDLE;
          frame_cnt_r[i] <= {FC_W{1'b0}};
        end else begin
          case (state_r[i])
            IDLE: begin
              if (db_rise_s[i]) begin
                state_r[i]     <= HOLD;
                frame_cnt_r[i] <= {FC_W{1'b0}};
              end
            end
            HOLD: begin
              if (frame_tick_s) begin
                if ((int'(frame_cnt_r[i]) + 32'sd1) >= (REPEAT_FRAMES - 32'sd1)) begin
                  state_r[i] <= REPEAT;
                end else begin
                  frame_cnt_r[i] <= frame_cnt_r[i] + FC_W'(1'b1);
                end
              end
            end
            REPEAT: begin
              state_r[i] <= REPEAT;
            end
            default: begin
              state_r[i]     <= IDLE;
              frame_cnt_r[i] <= {FC_W{1'b0}};
            end
          endcase
        end
      end
    end
  end

  // Pending move flags: set by button edges, cleared at every commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_inc_r <= 1'b0;
      pend_dec_r <= 1'b0;
      pend_ctr_r <= 1'b0;
    end else if (frame_tick_s) begin
      pend_inc_r <= 1'b0;
      pend_dec_r <= 1'b0;
      pend_ctr_r <= 1'b0;
    end else begin
      pend_inc_r <= pend_inc_r | db_rise_s[0];
      pend_dec_r <= pend_dec_r | db_rise_s[1];
      pend_ctr_r <= pend_ctr_r | db_rise_s[2];
    end
  end

  // Resolve the requests seen at a commit into the next coordinates.
  // Edges and repeats arriving in the commit cycle itself are included.
  always_comb begin
    req_inc_s  = pend_inc_r | db_rise_s[0] | repeat_fire_s[0];
    req_dec_s  = pend_dec_r | db_rise_s[1] | repeat_fire_s[1];
    req_ctr_s  = pend_ctr_r | db_rise_s[2];
    axis_cur_s = sw[0] ? cursor_y_r : cursor_x_r;
    axis_hi_s  = sw[0] ? Y_HI : X_HI;
    axis_new_s = step_coord(axis_cur_s, sw[7:4], req_dec_s, LO_LIM, axis_hi_s, WRAP_EN);
    next_x_s   = cursor_x_r;
    next_y_s   = cursor_y_r;
    if (req_ctr_s) begin
      next_x_s = X_RST;
      next_y_s = Y_RST;
    end else if (req_inc_s ^ req_dec_s) begin
      if (sw[0]) begin
        next_y_s = axis_new_s;
      end else begin
        next_x_s = axis_new_s;
      end
    end else begin
      next_x_s = cursor_x_r;
      next_y_s = cursor_y_r;
    end
    changed_s = (next_x_s != cursor_x_r) || (next_y_s != cursor_y_r);
  end

  // Committed position and change pulse, updated only at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_x_r <= X_RST;
      cursor_y_r <= Y_RST;
      moved_r    <= 1'b0;
    end else if (frame_tick_s) begin
      cursor_x_r <= next_x_s;
      cursor_y_r <= next_y_s;
      moved_r    <= changed_s;
    end else begin
      moved_r    <= 1'b0;
    end
  end

  assign cursor_x = cursor_x_r;
  assign cursor_y = cursor_y_r;
  assign moved    = moved_r;

endmodule

// File: tb/tb_crosshair_pos_ctrl.sv
// Directed bench for crosshair_pos_ctrl with short debounce/repeat settings
// and short hand-driven frames.
module tb_crosshair_pos_ctrl;

  localparam int FRAME_LOW = 30;

  logic       clk;
  logic       rst_n;
  logic       vsync;
  logic [2:0] btn;
  logic [7:0] sw;
  logic [9:0] cursor_x;
  logic [9:0] cursor_y;
  logic       moved;

  int   n_checks  = 0;
  int   n_pass    = 0;
  int   moved_cnt = 0;
  logic moved_at;
  logic moved_after;
  int   hold_y [5];
  int   exp_edge1;
  int   exp_edge2;
  int   exp_m2;

  crosshair_pos_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_FRAMES  (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync   (vsync),
    .btn     (btn),
    .sw      (sw),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .moved   (moved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle the change pulse is high.
  always @(negedge clk) begin
    if (moved === 1'b1) moved_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One frame: vsync rising edge, capture the pulse at and after the commit.
  task automatic frame();
    vsync = 1'b1;
    @(posedge clk); #1 moved_at = moved;
    @(posedge clk); #1 moved_after = moved;
    @(negedge clk);
    vsync = 1'b0;
    repeat (FRAME_LOW) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] b);
    btn = b;
    repeat (12) @(negedge clk);
    btn = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    hold_y = '{224, 224, 208, 192, 176};
`ifdef CROSSHAIR_WRAP_EN
    exp_edge1 = 18;  exp_edge2 = 22;  exp_m2 = 1;
`else
    exp_edge1 = 621; exp_edge2 = 621; exp_m2 = 0;
`endif
    rst_n = 1'b0; vsync = 1'b0; btn = 3'b000; sw = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_x", cursor_x, 300);
    check("rst_y", cursor_y, 240);
    check("rst_moved", moved, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // idle frames
    for (int f = 0; f < 3; f++) frame();
    check("idle_x", cursor_x, 300);
    check("idle_y", cursor_y, 240);
    check("idle_moved_cnt", moved_cnt, 0);

    // reset with an increment pending aborts it
    sw = 8'h30; btn = 3'b001;
    repeat (12) @(negedge clk);
    rst_n = 1'b0; btn = 3'b000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    frame();
    check("abort_x", cursor_x, 300);
    check("abort_moved", moved_at, 0);
    check("abort_moved_cnt", moved_cnt, 0);

    // bouncy increment press, x step 4
    btn = 3'b001; @(negedge clk);
    btn = 3'b000; @(negedge clk);
    btn = 3'b001; repeat (10) @(negedge clk);
    btn = 3'b000; repeat (12) @(negedge clk);
    check("pre_commit_x", cursor_x, 300);
    frame();
    check("bounce_x", cursor_x, 304);
    check("bounce_moved_at", moved_at, 1);
    check("bounce_moved_after", moved_after, 0);
    frame();
    check("once_x", cursor_x, 304);
    check("once_moved_cnt", moved_cnt, 1);

    // held decrement on y, step 16, with auto-repeat
    sw = 8'hF1; btn = 3'b010;
    repeat (12) @(negedge clk);
    for (int f = 0; f < 5; f++) begin
      frame();
      check($sformatf("hold_y%0d", f + 1), cursor_y, hold_y[f]);
    end
    btn = 3'b000; repeat (12) @(negedge clk);
    frame();
    check("hold_rel_y", cursor_y, 176);
    check("hold_x", cursor_x, 304);

    // increment and decrement together cancel
    btn = 3'b011; repeat (12) @(negedge clk);
    frame(); frame();
    btn = 3'b000; repeat (12) @(negedge clk);
    frame();
    check("both_x", cursor_x, 304);
    check("both_y", cursor_y, 176);
    check("both_moved_cnt", moved_cnt, 5);

    // recentre
    press(3'b100);
    check("ctr_wait_y", cursor_y, 176);
    frame();
    check("ctr_x", cursor_x, 300);
    check("ctr_y", cursor_y, 240);
    check("ctr_moved", moved_at, 1);

    // climb x to 620 with step 16 repeats
    sw = 8'hF0; btn = 3'b001;
    repeat (12) @(negedge clk);
    repeat (21) frame();
    btn = 3'b000; repeat (12) @(negedge clk);
    frame();
    check("climb_x", cursor_x, 620);

    // step 4 past the right limit, twice
    sw = 8'h30;
    press(3'b001); frame();
    check("edge1_x", cursor_x, exp_edge1);
    check("edge1_moved", moved_at, 1);
    press(3'b001); frame();
    check("edge2_x", cursor_x, exp_edge2);
    check("edge2_moved", moved_at, exp_m2);

    // axis is sampled at the commit edge
    press(3'b001);
    sw = 8'h31;
    frame();
    check("axis_y", cursor_y, 244);
    check("axis_x", cursor_x, exp_edge2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
